// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_e;

  localparam int MUL_CYCLES_DEF = 4;
  localparam int DIV_CYCLES_DEF = 32;

  // sll $0,$0,0 -- what IF/ID and ID/EX consumers load on flush or bubble
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/hazard_ctrl_md_sequencer.sv
// Mul/div occupancy sequencer: start pulse, busy window and HI/LO-written pulse.
module md_sequencer
  import hazard_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int CNT_W      = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic is_div_i,
  input  logic block_i,
  output logic go_o,
  output logic busy_o,
  output logic done_o,
  output logic in_busy_o
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 2);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 2);

  md_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] load_d;
  logic             accept;

  assign accept    = start_i & ~block_i & (state_q != BUSY) & ~rst;
  assign load_d    = is_div_i ? DIV_LOAD : MUL_LOAD;
  assign go_o      = accept;
  assign in_busy_o = (state_q == BUSY);
  assign busy_o    = ~rst & ((state_q == BUSY) | accept);
  assign done_o    = ~rst & (state_q == DONE);

  // The go cycle counts as the first occupied cycle, hence the N-2 load.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= BUSY;
            cnt_q   <= load_d;
          end
        end
        BUSY: begin
          if (cnt_q == '0) begin
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        DONE: begin
          if (accept) begin
            state_q <= BUSY;
            cnt_q   <= load_d;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use and mul/div stalls, branch flush,
// mul/div sequencing and a saturating stall statistics counter.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int CNT_W      = 6,
  parameter int STAT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        rs_id,
  input  logic [4:0]        rt_id,
  input  logic              rs_used_id,
  input  logic              rt_used_id,
  input  logic [4:0]        rd_ex,
  input  logic              memread_ex,
  input  logic              branch_taken_ex,
  input  logic              md_start_id,
  input  logic              md_is_div_id,
  input  logic              hilo_read_id,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              md_go,
  output logic              md_busy,
  output logic              md_done,
  output logic [STAT_W-1:0] stall_cycles
);

  logic              lu_hz;
  logic              md_hz;
  logic              stall;
  logic              md_in_busy;
  logic [STAT_W-1:0] stall_cycles_q;

  assign lu_hz = memread_ex & (rd_ex != 5'd0) &
                 ((rs_used_id & (rs_id == rd_ex)) | (rt_used_id & (rt_id == rd_ex)));
  assign md_hz = md_in_busy & (md_start_id | hilo_read_id);
  assign stall = (lu_hz | md_hz) & ~branch_taken_ex & ~rst;

  md_sequencer #(
    .MUL_CYCLES(MUL_CYCLES),
    .DIV_CYCLES(DIV_CYCLES),
    .CNT_W     (CNT_W)
  ) u_md_sequencer (
    .clk      (clk),
    .rst      (rst),
    .start_i  (md_start_id),
    .is_div_i (md_is_div_id),
    .block_i  (stall | branch_taken_ex),
    .go_o     (md_go),
    .busy_o   (md_busy),
    .done_o   (md_done),
    .in_busy_o(md_in_busy)
  );

  // A taken branch wins over any stall: the stalled ID instruction is wrong-path anyway.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (!rst) begin
      if (branch_taken_ex) begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end else if (stall) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
    end else if (stall && (stall_cycles_q != '1)) begin
      stall_cycles_q <= stall_cycles_q + STAT_W'(1);
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: randomized and directed cycles against
// an occupancy-count reference model, checked by an independent monitor.
module tb_hazard_ctrl;

  localparam int MUL_N     = 4;
  localparam int DIV_N     = 32;
  localparam int STAT_BITS = 4;
  localparam int STAT_MAX  = (1 << STAT_BITS) - 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [4:0]           rs_id, rt_id, rd_ex;
  logic                 rs_used_id, rt_used_id, memread_ex, branch_taken_ex;
  logic                 md_start_id, md_is_div_id, hilo_read_id;
  logic                 pc_write, ifid_write, ifid_flush, idex_bubble;
  logic                 md_go, md_busy, md_done;
  logic [STAT_BITS-1:0] stall_cycles;

  typedef struct {
    bit pc;
    bit ifidW;
    bit flush;
    bit bubble;
    bit go;
    bit busy;
    bit done;
    int stat;
  } exp_t;

  exp_t expQ[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: cycles the unit stays occupied after the go cycle,
  // a pending HI/LO-written flag, and the stall count.
  int   busyLeft  = 0;
  bit   doneNow   = 1'b0;
  int   statModel = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .MUL_CYCLES(MUL_N),
    .DIV_CYCLES(DIV_N),
    .CNT_W     (6),
    .STAT_W    (STAT_BITS)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rs_id          (rs_id),
    .rt_id          (rt_id),
    .rs_used_id     (rs_used_id),
    .rt_used_id     (rt_used_id),
    .rd_ex          (rd_ex),
    .memread_ex     (memread_ex),
    .branch_taken_ex(branch_taken_ex),
    .md_start_id    (md_start_id),
    .md_is_div_id   (md_is_div_id),
    .hilo_read_id   (hilo_read_id),
    .pc_write       (pc_write),
    .ifid_write     (ifid_write),
    .ifid_flush     (ifid_flush),
    .idex_bubble    (idex_bubble),
    .md_go          (md_go),
    .md_busy        (md_busy),
    .md_done        (md_done),
    .stall_cycles   (stall_cycles)
  );

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle of inputs and pushes the response the model predicts for it.
  task automatic applyStimulus(input bit r, input int rs, input int rt, input bit rsu,
                               input bit rtu, input int rd, input bit mr, input bit br,
                               input bit ms, input bit dv, input bit hr);
    exp_t e;
    bit   lu, md, stl, acc, nextDone;
    @(posedge clk);
    #1;
    rst = r; rs_id = 5'(rs); rt_id = 5'(rt); rs_used_id = rsu; rt_used_id = rtu;
    rd_ex = 5'(rd); memread_ex = mr; branch_taken_ex = br;
    md_start_id = ms; md_is_div_id = dv; hilo_read_id = hr;

    lu  = mr && (rd != 0) && ((rsu && rs == rd) || (rtu && rt == rd));
    md  = (busyLeft > 0) && (ms || hr);
    stl = (lu || md) && !br;
    e.stat = statModel;
    if (r) begin
      e.pc = 1; e.ifidW = 1; e.flush = 0; e.bubble = 0;
      e.go = 0; e.busy = 0; e.done = 0;
      statModel = 0; busyLeft = 0; doneNow = 0;
    end else begin
      acc      = ms && !stl && !br && (busyLeft == 0);
      e.pc     = !stl || br;
      e.ifidW  = !stl || br;
      e.flush  = br;
      e.bubble = br || stl;
      e.go     = acc;
      e.busy   = (busyLeft > 0) || acc;
      e.done   = doneNow;
      nextDone = (busyLeft == 1);
      if (busyLeft > 0) busyLeft--;
      if (acc) busyLeft = (dv ? DIV_N : MUL_N) - 1;
      doneNow = nextDone;
      if (stl && statModel < STAT_MAX) statModel++;
    end
    expQ.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: every cycle with an issued stimulus, compare the DUT against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("pc_write",     int'(pc_write),     int'(e.pc));
        checkOutput("ifid_write",   int'(ifid_write),   int'(e.ifidW));
        checkOutput("ifid_flush",   int'(ifid_flush),   int'(e.flush));
        checkOutput("idex_bubble",  int'(idex_bubble),  int'(e.bubble));
        checkOutput("md_go",        int'(md_go),        int'(e.go));
        checkOutput("md_busy",      int'(md_busy),      int'(e.busy));
        checkOutput("md_done",      int'(md_done),      int'(e.done));
        checkOutput("stall_cycles", int'(stall_cycles), e.stat);
      end
    end
  end

  initial begin
    rst = 1; rs_id = 0; rt_id = 0; rs_used_id = 0; rt_used_id = 0; rd_ex = 0;
    memread_ex = 0; branch_taken_ex = 0; md_start_id = 0; md_is_div_id = 0; hilo_read_id = 0;

    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);

    // load-use on $3, then the same shape with rd_ex=$0
    applyStimulus(0, 3, 5, 1, 0, 3, 1, 0, 0, 0, 0);
    idle(1);
    applyStimulus(0, 0, 5, 1, 0, 0, 1, 0, 0, 0, 0);
    idle(1);

    // multiply followed by mfhi held in ID until it may proceed
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(2);

    // back-to-back divides
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 32; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    idle(34);

    // taken branch with a load-use hazard and a mul start in ID
    applyStimulus(0, 4, 0, 1, 0, 4, 1, 1, 1, 0, 0);
    idle(6);

    // reset in the middle of a divide
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    idle(20);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(40);

    // long load-use run drives the counter into saturation
    for (int i = 0; i < 20; i++) applyStimulus(0, 0, 7, 0, 1, 7, 1, 0, 0, 0, 0);
    idle(2);

    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 199) == 0,
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)), $urandom_range(0, 2) == 0,
                    $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                    1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
    end

    @(negedge clk);
    #1;
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage MIPS core; sits beside the forwarding unit and drives PC, IF/ID and ID/EX control.
- Detects load-use hazards that forwarding cannot cover, squashes wrong-path instructions on a taken branch, and sequences the multi-cycle mul/div unit.
- Stalls the front end while mul/div is busy and a dependent instruction (new mul/div, mfhi/mflo) is in ID.
- Keeps a saturating stall-cycle statistics counter.

Parameters:
MUL_CYCLES, 4, cycles a multiply occupies the mul/div unit (>=2)
DIV_CYCLES, 32, cycles a divide occupies the mul/div unit (>=2)
CNT_W, 6, width of mul/div cycle counter; must hold max(MUL_CYCLES,DIV_CYCLES)-1
STAT_W, 16, width of stall statistics counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rs_id  in  5  rs field of instruction in ID
rt_id  in  5  rt field of instruction in ID
rs_used_id  in  1  ID instruction reads rs
rt_used_id  in  1  ID instruction reads rt
rd_ex  in  5  destination register of instruction in EX
memread_ex  in  1  EX instruction is a load
branch_taken_ex  in  1  branch/jump in EX resolved taken
md_start_id  in  1  ID instruction is mult/multu/div/divu
md_is_div_id  in  1  qualifies md_start_id: 1=divide, 0=multiply
hilo_read_id  in  1  ID instruction is mfhi/mflo
pc_write  out  1  PC register enable
ifid_write  out  1  IF/ID register enable
ifid_flush  out  1  clear IF/ID to nop
idex_bubble  out  1  load nop into ID/EX
md_go  out  1  one-cycle start pulse to mul/div datapath
md_busy  out  1  mul/div unit occupied
md_done  out  1  one-cycle pulse: HI/LO written this edge
stall_cycles  out  STAT_W  saturating count of stall cycles

Behaviour:
- Reset (rst=1 at posedge): FSM -> IDLE, counter -> 0, stall_cycles -> 0. While rst is high, outputs are pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, md_go=0, md_busy=0, md_done=0. Reset in BUSY aborts the operation; no md_done is issued.
- lu_hz (comb) = memread_ex & rd_ex!=0 & ((rs_used_id & rs_id==rd_ex) | (rt_used_id & rt_id==rd_ex)).
- md_hz (comb) = (state==BUSY) & (md_start_id | hilo_read_id). mfhi/mflo in DONE does not stall; HI/LO are valid that cycle.
- stall = (lu_hz | md_hz) & ~branch_taken_ex.
- Flush (branch_taken_ex=1): ifid_flush=1, idex_bubble=1, pc_write=1, ifid_write=1. Flush overrides every stall.
- Stall: pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0.
- Otherwise: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0.
- All control outputs are combinational from current state and inputs, zero latency.
- Mul/div FSM, states IDLE, BUSY, DONE:
  - accept = md_start_id & ~stall & ~branch_taken_ex & state!=BUSY.
  - IDLE or DONE with accept: md_go=1 same cycle; next BUSY; cnt <= (md_is_div_id ? DIV_CYCLES : MUL_CYCLES) - 2.
  - BUSY: cnt decrements each cycle; at cnt==0 -> DONE.
  - DONE: md_done=1 for one cycle; next IDLE, or BUSY if accept.
  - md_busy = (state==BUSY), or md_go is asserted.
  - Net effect: md_go cycle plus BUSY cycles total exactly N cycles; md_done on cycle N+1.
- A md_start_id blocked by stall or flush is not accepted and is re-evaluated each cycle.
- stall_cycles increments by 1 on each cycle with stall=1; holds at all-ones (saturates); never wraps.

Decomposition:
- Shared package hazard_pkg holds: FSM state typedef (IDLE=2'd0, BUSY=2'd1, DONE=2'd2), default MUL_CYCLES/DIV_CYCLES constants, and the nop encoding used by flush consumers.
- One sub-module is natural: md_sequencer, containing the FSM, counter, and md_go/md_busy/md_done.
- Top level hazard_ctrl holds hazard detection, output muxing and the statistics counter.

Test Plan:
- Load-use: lw $3 in EX (memread_ex=1, rd_ex=3), ID rs_id=3 with rs_used_id=1 -> one cycle pc_write=0, ifid_write=0, idex_bubble=1, then stall_cycles=1; the same case with rd_ex=0 gives no stall.
- Multiply then mfhi: md_start_id=1, md_is_div_id=0 -> md_go pulse; mfhi held in ID stalls exactly 3 cycles (BUSY); md_done in the 5th cycle; mfhi proceeds in DONE; stall_cycles=3.
- Divide back-to-back: second div in ID during first -> stall for 31 cycles; accepted in DONE cycle (md_go=1, md_done=1 same cycle); second md_done 32 cycles later.
- Branch flush with load-use present: branch_taken_ex=1 and lu_hz=1 -> ifid_flush=1, idex_bubble=1, pc_write=1; stall_cycles unchanged; a concurrent md_start_id is not accepted.
- Reset mid-divide: rst at BUSY cnt=10 -> next cycle state IDLE, md_busy=0, no md_done ever; stall_cycles=0.
- Saturation with STAT_W=4: 20 consecutive stall cycles -> stall_cycles reaches 15 and stays 15.
